// File: rtl/vector_regfile_bank_mp.sv
// Multi-read-port vector register file bank with masked write-first bypass,
// live v0 mask output and a sequential bulk-clear engine.
module vector_regfile_bank_mp #(
  parameter int XLEN       = 32,
  parameter int NUM_THREAD = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD*AW-1:0]              rsidx_i,
  input  logic [NUM_RD-1:0]                 rsren_i,
  output logic [NUM_RD*XLEN*NUM_THREAD-1:0] rs_o,
  output logic [NUM_RD-1:0]                 rs_valid_o,
  input  logic [XLEN*NUM_THREAD-1:0]        rd_i,
  input  logic [AW-1:0]                     rdidx_i,
  input  logic                              rdwen_i,
  input  logic [NUM_THREAD-1:0]             rdwmask_i,
  output logic                              wr_ready_o,
  output logic [XLEN*NUM_THREAD-1:0]        v0_o,
  input  logic                              clr_req_i,
  output logic                              clr_busy_o,
  output logic                              clr_done_o
);

  localparam int W = XLEN * NUM_THREAD;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          state;
  logic [AW-1:0] cnt;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  bmask;
  logic [W-1:0]  wmerge;
  logic          wr_acc;
  logic [AW-1:0] ridx [NUM_RD];

  assign clr_busy_o = (state == ST_CLEAR);
  assign wr_ready_o = !clr_busy_o;
  assign wr_acc     = rdwen_i && wr_ready_o;
  assign v0_o       = mem[0];

  always_comb begin
    bmask = '0;
    for (int j = 0; j < NUM_THREAD; j++)
      bmask[XLEN*j +: XLEN] = {XLEN{rdwmask_i[j]}};
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++)
      ridx[p] = rsidx_i[AW*p +: AW];
  end

  // Merge: masked lanes take new data, the rest keep the old entry
  assign wmerge = (mem[rdidx_i] & ~bmask) | (rd_i & bmask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      clr_done_o <= 1'b0;
    end else begin
      clr_done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_req_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= ST_IDLE;
            clr_done_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (clr_busy_o && cnt == AW'(k))
          mem[k] <= '0;
        else if (wr_acc && rdidx_i == AW'(k))
          mem[k] <= wmerge;
      end
    end
  end

  // Write-first: a read hitting the write index sees the merged value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_o       <= '0;
      rs_valid_o <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rs_valid_o[p] <= rsren_i[p] && wr_ready_o;
        if (rsren_i[p] && wr_ready_o) begin
          if (wr_acc && ridx[p] == rdidx_i)
            rs_o[W*p +: W] <= wmerge;
          else
            rs_o[W*p +: W] <= mem[ridx[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile_bank_mp.sv
// Self-checking bench for vector_regfile_bank_mp: directed table,
// randomized traffic against a lane-array model, and clear/reset sequences.
module tb_vector_regfile_bank_mp;

  localparam int XLEN  = 32;
  localparam int NT    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int W     = XLEN * NT;

  logic               clk;
  logic               rst_n;
  logic [NRD*AW-1:0]  rsidx;
  logic [NRD-1:0]     rsren;
  logic [NRD*W-1:0]   rs;
  logic [NRD-1:0]     rs_valid;
  logic [W-1:0]       rd;
  logic [AW-1:0]      rdidx;
  logic               rdwen;
  logic [NT-1:0]      rdwmask;
  logic               wr_ready;
  logic [W-1:0]       v0;
  logic               clr_req;
  logic               clr_busy;
  logic               clr_done;

  vector_regfile_bank_mp #(
    .XLEN(XLEN), .NUM_THREAD(NT), .DEPTH(DEPTH), .NUM_RD(NRD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rsidx_i(rsidx), .rsren_i(rsren),
    .rs_o(rs), .rs_valid_o(rs_valid),
    .rd_i(rd), .rdidx_i(rdidx), .rdwen_i(rdwen), .rdwmask_i(rdwmask),
    .wr_ready_o(wr_ready), .v0_o(v0),
    .clr_req_i(clr_req), .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0]    mdl [DEPTH][NT];
  logic [W-1:0]   exp_rs [NRD];
  logic [NRD-1:0] exp_val;
  bit             busy_m;

  typedef struct {
    bit          wen;
    int          widx;
    logic [31:0] wmask;
    logic [31:0] wval;
    logic [1:0]  ren;
    int          r0;
    int          r1;
    logic [1:0]  ev;
    logic [31:0] em0, ea0, eb0;
    logic [31:0] em1, ea1, eb1;
    logic [31:0] v0v;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
    int l;
    tests++;
    if (act !== exp) begin
      fails++;
      l = 0;
      for (int j = NT - 1; j >= 0; j--)
        if (act[XLEN*j +: XLEN] !== exp[XLEN*j +: XLEN]) l = j;
      $display("FAIL %s: lane %0d got %h expected %h", nm, l,
               act[XLEN*l +: XLEN], exp[XLEN*l +: XLEN]);
    end
  endtask

  function automatic logic [W-1:0] ent(input int i);
    logic [W-1:0] v;
    for (int j = 0; j < NT; j++) v[XLEN*j +: XLEN] = mdl[i][j];
    return v;
  endfunction

  function automatic logic [W-1:0] pat(input logic [31:0] m,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [W-1:0] v;
    for (int j = 0; j < NT; j++) v[XLEN*j +: XLEN] = m[j] ? a : b;
    return v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < NT; j++) mdl[i][j] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of traffic and advance the reference model
  task automatic drive(input bit wen, input int widx,
                       input logic [NT-1:0] wm, input logic [W-1:0] wd,
                       input logic [NRD-1:0] ren, input int r0,
                       input int r1);
    rdwen   = wen;
    rdidx   = AW'(widx);
    rdwmask = wm;
    rd      = wd;
    rsren   = ren;
    rsidx   = {AW'(r1), AW'(r0)};
    if (!busy_m) begin
      if (wen)
        for (int j = 0; j < NT; j++)
          if (wm[j]) mdl[widx][j] = wd[XLEN*j +: XLEN];
      exp_val = ren;
      if (ren[0]) exp_rs[0] = ent(r0);
      if (ren[1]) exp_rs[1] = ent(r1);
    end else begin
      exp_val = '0;
    end
  endtask

  task automatic check_model();
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rs_valid[%0d]", p), 32'(rs_valid[p]), 32'(exp_val[p]));
      chk_vec($sformatf("rs[%0d]", p), rs[W*p +: W], exp_rs[p]);
    end
    chk_vec("v0", v0, ent(0));
  endtask

  task automatic check_reset_outs();
    chk("rst rs_valid", 32'(rs_valid), 32'h0);
    chk_vec("rst rs0", rs[W-1:0], '0);
    chk_vec("rst rs1", rs[2*W-1:W], '0);
    chk_vec("rst v0", v0, '0);
    chk("rst busy", 32'(clr_busy), 32'h0);
    chk("rst done", 32'(clr_done), 32'h0);
    chk("rst ready", 32'(wr_ready), 32'h1);
  endtask

  // Run n cycles after the sampling edge E0 of a clear request
  task automatic run_clear(input int n, inout int nbusy, inout int ndone);
    for (int i = 0; i < n; i++) begin
      busy_m = (i < DEPTH);
      drive(1'b0, 0, '0, '0, 2'b11, 2, i % DEPTH);
      if (i < DEPTH)
        for (int j = 0; j < NT; j++) mdl[i][j] = '0;
      step();
      nbusy += !wr_ready;
      ndone += clr_done;
      chk($sformatf("clr ready i=%0d", i), 32'(wr_ready),
          32'(i >= DEPTH - 1));
      chk($sformatf("clr done i=%0d", i), 32'(clr_done),
          32'(i == DEPTH - 1));
      check_model();
    end
    busy_m = 1'b0;
  endtask

  initial begin
    int nbusy;
    int ndone;
    logic [W-1:0]  wd;
    logic [NT-1:0] wm;
    int widx, r0, r1;

    tbl[0] = '{0, 0, 32'h0, 32'h0, 2'b11, 5, 5, 2'b11,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1, 3, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 2'b00, 0, 0, 2'b00,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2] = '{1, 3, 32'h3, 32'h1234_5678, 2'b00, 0, 0, 2'b00,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{0, 0, 32'h0, 32'h0, 2'b01, 3, 0, 2'b01,
               32'h3, 32'h1234_5678, 32'hAAAA_AAAA,
               32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{1, 7, 32'hFFFF_FFFF, 32'h1111_1111, 2'b00, 0, 0, 2'b00,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{1, 7, 32'h1, 32'hDEAD_BEEF, 2'b11, 7, 7, 2'b11,
               32'h1, 32'hDEAD_BEEF, 32'h1111_1111,
               32'h1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0};
    tbl[6] = '{1, 0, 32'hFFFF_FFFF, 32'h1, 2'b00, 0, 0, 2'b00,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    tbl[7] = '{1, 7, 32'h0, 32'h5555_5555, 2'b11, 7, 3, 2'b11,
               32'h1, 32'hDEAD_BEEF, 32'h1111_1111,
               32'h3, 32'h1234_5678, 32'hAAAA_AAAA, 32'h1};
    tbl[8] = '{0, 0, 32'h0, 32'h0, 2'b11, 0, 3, 2'b11,
               32'h0, 32'h0, 32'h1,
               32'h3, 32'h1234_5678, 32'hAAAA_AAAA, 32'h1};

    rst_n = 1'b0; clr_req = 1'b0; busy_m = 1'b0;
    rdwen = 1'b0; rdidx = '0; rdwmask = '0; rd = '0;
    rsren = '0; rsidx = '0;
    model_zero();
    exp_rs[0] = '0; exp_rs[1] = '0; exp_val = '0;
    #3;
    check_reset_outs();
    #4 rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].wen, tbl[i].widx, tbl[i].wmask, {NT{tbl[i].wval}},
            tbl[i].ren, tbl[i].r0, tbl[i].r1);
      step();
      chk($sformatf("tbl%0d valid", i), 32'(rs_valid), 32'(tbl[i].ev));
      if (tbl[i].ev[0])
        chk_vec($sformatf("tbl%0d rs0", i), rs[W-1:0],
                pat(tbl[i].em0, tbl[i].ea0, tbl[i].eb0));
      if (tbl[i].ev[1])
        chk_vec($sformatf("tbl%0d rs1", i), rs[2*W-1:W],
                pat(tbl[i].em1, tbl[i].ea1, tbl[i].eb1));
      chk_vec($sformatf("tbl%0d v0", i), v0, {NT{tbl[i].v0v}});
    end

    for (int c = 0; c < 300; c++) begin
      widx = $urandom_range(0, 7);
      for (int j = 0; j < NT; j++) wd[XLEN*j +: XLEN] = $urandom;
      case ($urandom_range(0, 3))
        0: wm = '0;
        1: wm = '1;
        default: wm = $urandom;
      endcase
      r0 = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 7);
      r1 = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 7);
      drive(1'($urandom), widx, wm, wd, 2'($urandom), r0, r1);
      step();
      check_model();
    end

    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, k, '1, {NT{32'(k * 7 + 1)}}, 2'b00, 0, 0);
      step();
    end
    clr_req = 1'b1;
    drive(1'b1, 2, '1, {NT{32'hCAFE_0002}}, 2'b00, 0, 0);
    step();
    clr_req = 1'b0;
    chk("clr E0 ready", 32'(wr_ready), 32'h0);
    chk("clr E0 busy", 32'(clr_busy), 32'h1);
    nbusy = !wr_ready;
    ndone = 0;
    run_clear(DEPTH + 2, nbusy, ndone);
    chk("clr busy cycles", 32'(nbusy), 32'(DEPTH));
    chk("clr done pulses", 32'(ndone), 32'h1);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 0, '0, '0, 2'b11, k, DEPTH - 1 - k);
      step();
      check_model();
    end

    drive(1'b1, 4, '1, {NT{32'h4444_4444}}, 2'b00, 0, 0);
    step();
    drive(1'b1, 0, '1, {NT{32'h0000_00FF}}, 2'b11, 4, 0);
    step();
    check_model();
    clr_req = 1'b1;
    drive(1'b0, 0, '0, '0, 2'b00, 0, 0);
    step();
    clr_req = 1'b0;
    nbusy = 1;
    ndone = 0;
    run_clear(10, nbusy, ndone);
    chk("midclr no done", 32'(ndone), 32'h0);
    rst_n = 1'b0;
    #2;
    model_zero();
    exp_rs[0] = '0; exp_rs[1] = '0; exp_val = '0;
    check_reset_outs();
    #2 rst_n = 1'b1;
    drive(1'b0, 0, '0, '0, 2'b00, 0, 0);
    step();
    chk("post rst done", 32'(clr_done), 32'h0);
    chk("post rst ready", 32'(wr_ready), 32'h1);
    check_model();

    drive(1'b1, 4, '1, {NT{32'h7777_0004}}, 2'b00, 0, 0);
    step();
    clr_req = 1'b1;
    drive(1'b0, 0, '0, '0, 2'b00, 0, 0);
    step();
    clr_req = 1'b0;
    nbusy = !wr_ready;
    ndone = 0;
    run_clear(DEPTH + 2, nbusy, ndone);
    chk("clr2 busy cycles", 32'(nbusy), 32'(DEPTH));
    chk("clr2 done pulses", 32'(ndone), 32'h1);
    drive(1'b0, 0, '0, '0, 2'b11, 4, 0);
    step();
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
